// File: rtl/jk_pkg.sv
// Shared types and JK excitation helper for the step driver.
// Build option: JK_DONTCARE_TOGGLE_EN drives don't-care J/K terms to 1.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    localparam logic       J_HOLD  = 1'b0;
    localparam logic       K_HOLD  = 1'b0;
    localparam logic [1:0] JK_HOLD = {J_HOLD, K_HOLD};

`ifdef JK_DONTCARE_TOGGLE_EN
    localparam logic JK_DC = 1'b1;
`else
    localparam logic JK_DC = 1'b0;
`endif

    // Returns {J,K} that moves one flop from q_bit to nxt_bit.
    function automatic logic [1:0] jk_excite(
        input logic q_bit,
        input logic nxt_bit
    );
        logic [1:0] jk;
        unique case ({q_bit, nxt_bit})
            2'b01:   jk = {1'b1, JK_DC};
            2'b10:   jk = {JK_DC, 1'b1};
            default: jk = JK_HOLD;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_ff_bank.sv
// Bank of behavioural JK flip-flops with synchronous active-high reset.
// Each bit follows q' = J&~q | ~K&q.
module jk_ff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

endmodule

// File: rtl/jk_step_driver.sv
// Steps a JK register bank one count per clock toward a handshaked target.
// Build option: JK_DONTCARE_TOGGLE_EN selects toggle-form J/K for changing bits.
module jk_step_driver
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] tgt_r;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j_x;
    logic [WIDTH-1:0] k_x;
    logic [WIDTH-1:0] j_c;
    logic [WIDTH-1:0] k_c;
    logic             up;
    logic             stepping;

    assign up       = tgt_r > q;
    assign nxt      = up ? q + ONE : q - ONE;
    assign stepping = (state == STEP);

    always_comb begin
        j_x = '0;
        k_x = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j_x[i], k_x[i]} = jk_excite(q[i], nxt[i]);
        end
    end

    // Outside STEP the bank sees hold excitation, so q only moves while stepping.
    assign j_c = stepping ? j_x : {WIDTH{J_HOLD}};
    assign k_c = stepping ? k_x : {WIDTH{K_HOLD}};

    jk_ff_bank #(
        .WIDTH(WIDTH)
    ) u_bank (
        .clk  (clk),
        .reset(reset),
        .j    (j_c),
        .k    (k_c),
        .q    (q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tgt_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tgt_ready <= 1'b1;
            j_out     <= '0;
            k_out     <= '0;
        end else begin
            j_out <= j_c;
            k_out <= k_c;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tgt_valid && tgt_ready) begin
                        tgt_r     <= tgt_data;
                        tgt_ready <= 1'b0;
                        if (tgt_data == q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= STEP;
                            busy  <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    if (nxt == tgt_r) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    tgt_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    tgt_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_step_driver.sv
// Self-checking bench for jk_step_driver (WIDTH=4 and WIDTH=1 instances).
// Expected values come from a target-sequence model built from the excitation table.
module tb_jk_step_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v4 = 1'b0;
    logic [3:0] d4 = '0;
    logic       r4, b4, dn4;
    logic [3:0] q4, j4, k4;
    logic       v1 = 1'b0;
    logic [0:0] d1 = '0;
    logic       r1, b1, dn1;
    logic [0:0] q1, j1, k1;

    int checks = 0;
    int errors = 0;
    int mq = 0;
    int m1q = 0;

`ifdef JK_DONTCARE_TOGGLE_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    always #5 clk = ~clk;

    jk_step_driver #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .tgt_valid(v4), .tgt_ready(r4), .tgt_data(d4),
        .q(q4), .j_out(j4), .k_out(k4),
        .busy(b4), .done(dn4)
    );

    jk_step_driver #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset),
        .tgt_valid(v1), .tgt_ready(r1), .tgt_data(d1),
        .q(q1), .j_out(j1), .k_out(k1),
        .busy(b1), .done(dn1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // J/K straight from the excitation table: rising bits need J, falling bits need K.
    function automatic int exp_j(input int cur, input int nx, input int mask);
        int rise = ~cur & nx & mask;
        int fall = cur & ~nx & mask;
        return rise | (DC ? fall : 0);
    endfunction

    function automatic int exp_k(input int cur, input int nx, input int mask);
        int rise = ~cur & nx & mask;
        int fall = cur & ~nx & mask;
        return fall | (DC ? rise : 0);
    endfunction

    task automatic xfer4(input int t, input bit hold);
        int n = 0;
        while (r4 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(r4), 1);
        v4 = 1'b1;
        d4 = 4'(t);
        tick();
        if (hold) d4 = 4'd9;
        else v4 = 1'b0;
    endtask

    task automatic follow4(input int t);
        int old = mq;
        int n = (t > old) ? t - old : old - t;
        int cur = old;
        int nx;
        chk("xfer_q", 32'(q4), old);
        chk("xfer_busy", 32'(b4), (n != 0));
        chk("xfer_done", 32'(dn4), (n == 0));
        chk("xfer_ready", 32'(r4), 0);
        chk("xfer_j", 32'(j4), 0);
        chk("xfer_k", 32'(k4), 0);
        for (int s = 1; s <= n; s++) begin
            tick();
            nx = (t > cur) ? cur + 1 : cur - 1;
            chk("step_q", 32'(q4), nx);
            chk("step_j", 32'(j4), exp_j(cur, nx, 15));
            chk("step_k", 32'(k4), exp_k(cur, nx, 15));
            chk("step_busy", 32'(b4), (s != n));
            chk("step_done", 32'(dn4), (s == n));
            chk("step_ready", 32'(r4), 0);
            cur = nx;
        end
        tick();
        chk("idle_q", 32'(q4), t);
        chk("idle_busy", 32'(b4), 0);
        chk("idle_done", 32'(dn4), 0);
        chk("idle_ready", 32'(r4), 1);
        chk("idle_j", 32'(j4), 0);
        chk("idle_k", 32'(k4), 0);
        mq = t;
    endtask

    task automatic run1(input int t);
        int n = 0;
        while (r1 !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("w1_ready_timeout", 32'(r1), 1);
        v1 = 1'b1;
        d1 = 1'(t);
        tick();
        v1 = 1'b0;
        chk("w1_xfer_q", 32'(q1), m1q);
        chk("w1_xfer_done", 32'(dn1), (t == m1q));
        if (t != m1q) begin
            tick();
            chk("w1_q", 32'(q1), t);
            chk("w1_j", 32'(j1), exp_j(m1q, t, 1));
            chk("w1_k", 32'(k1), exp_k(m1q, t, 1));
            chk("w1_done", 32'(dn1), 1);
        end
        tick();
        chk("w1_ready", 32'(r1), 1);
        chk("w1_idle_done", 32'(dn1), 0);
        m1q = t;
    endtask

    initial begin
        int t;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_q", 32'(q4), 0);
        chk("rst_j", 32'(j4), 0);
        chk("rst_k", 32'(k4), 0);
        chk("rst_busy", 32'(b4), 0);
        chk("rst_done", 32'(dn4), 0);
        chk("rst_ready", 32'(r4), 1);

        xfer4(3, 0); follow4(3);
        xfer4(0, 0); follow4(0);
        xfer4(5, 0); follow4(5);
        xfer4(5, 0); follow4(5);

        // Reset in the middle of a 0->15 walk.
        xfer4(0, 0); follow4(0);
        xfer4(15, 0);
        for (int s = 1; s <= 7; s++) begin
            tick();
            chk("walk_q", 32'(q4), s);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mq = 0;
        chk("mid_rst_q", 32'(q4), 0);
        chk("mid_rst_busy", 32'(b4), 0);
        chk("mid_rst_done", 32'(dn4), 0);
        chk("mid_rst_ready", 32'(r4), 1);
        chk("mid_rst_j", 32'(j4), 0);

        // tgt_valid held with 9 during stepping: only taken once back in IDLE.
        xfer4(4, 1); follow4(4);
        xfer4(9, 0); follow4(9);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("once_q", 32'(q4), 9);
            chk("once_busy", 32'(b4), 0);
        end

        for (int r = 0; r < 10; r++) begin
            t = int'($urandom_range(0, 15));
            xfer4(t, 0);
            follow4(t);
        end

        m1q = 0;
        run1(1); run1(0); run1(1); run1(1); run1(0); run1(0); run1(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
